// File: rtl/rails_seq_ctrl.sv
// Railway shunting sequencer: decides push/pop commands for a one-track stack
// station so cars 1..N leave in a requested order. Define RAILS_OPCNT_EN for op_count.
module rails_seq_ctrl #(
    parameter int MAX_CARS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] data,
    output logic       busy,
    output logic       cmd_valid,
    output logic       cmd_op,
    output logic [3:0] cmd_car,
    output logic       done,
    output logic       result,
    output logic [4:0] op_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state, state_next;
    logic [3:0] len;
    logic [3:0] idx;
    logic [3:0] pos;
    logic [3:0] sp;
    logic [4:0] next_in;
    logic [3:0] order [MAX_CARS];
    logic [3:0] stack [MAX_CARS];
    logic [3:0] tgt;
    logic [3:0] top;
    logic       start, store, do_push, do_pop, finish, pass;

    assign tgt  = order[pos];
    assign top  = stack[(sp == 4'd0) ? 4'd0 : sp - 4'd1];
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Popping a matching top always wins over pushing; anything else is a dead end.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        store      = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        finish     = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && data != 4'd0 && {1'b0, data} <= 5'(MAX_CARS)) begin
                    start      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    store = 1'b1;
                    if (idx + 4'd1 == len) state_next = RUN;
                end
            end
            RUN: begin
                if (sp != 4'd0 && top == tgt) begin
                    do_pop = 1'b1;
                    if (pos + 4'd1 == len) begin
                        finish     = 1'b1;
                        pass       = 1'b1;
                        state_next = DONE;
                    end
                end else if (next_in <= {1'b0, tgt} && tgt <= len) begin
                    do_push = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // pos is left on the last entry after success so the order lookup stays in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= 4'd0;
            idx       <= 4'd0;
            pos       <= 4'd0;
            sp        <= 4'd0;
            next_in   <= 5'd0;
            cmd_valid <= 1'b0;
            cmd_op    <= 1'b0;
            cmd_car   <= 4'd0;
            result    <= 1'b0;
            for (int i = 0; i < MAX_CARS; i++) begin
                order[i] <= 4'd0;
                stack[i] <= 4'd0;
            end
        end else begin
            cmd_valid <= do_push | do_pop;
            cmd_op    <= do_pop;
            cmd_car   <= do_pop ? tgt : (do_push ? next_in[3:0] : 4'd0);
            if (start) begin
                len     <= data;
                idx     <= 4'd0;
                pos     <= 4'd0;
                sp      <= 4'd0;
                next_in <= 5'd1;
            end
            if (store) begin
                order[idx] <= data;
                idx        <= idx + 4'd1;
            end
            if (do_push) begin
                stack[sp] <= next_in[3:0];
                sp        <= sp + 4'd1;
                next_in   <= next_in + 5'd1;
            end
            if (do_pop) begin
                sp <= sp - 4'd1;
                if (!finish) pos <= pos + 4'd1;
            end
            if (finish) result <= pass;
        end
    end

`ifdef RAILS_OPCNT_EN
    logic [4:0] cnt;

    // Counts in step with the registered command so it reads 2N in the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt <= 5'd0;
        else if (start)             cnt <= 5'd0;
        else if (do_push || do_pop) cnt <= cnt + 5'd1;
    end

    assign op_count = cnt;
`else
    assign op_count = 5'd0;
`endif

endmodule

// File: tb/tb_rails_seq_ctrl.sv
// Self-checking bench for rails_seq_ctrl: directed shunting jobs plus random
// permutations compared against a queue-based station model.
module tb_rails_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] data;
    logic       busy;
    logic       cmd_valid;
    logic       cmd_op;
    logic [3:0] cmd_car;
    logic       done;
    logic       result;
    logic [4:0] op_count;

    int         n_checks = 0;
    int         n_fail   = 0;

    logic [3:0] ord [16];
    int         ord_n;
    logic [4:0] exp_q [$];
    logic [4:0] obs_q [$];
    logic       exp_result;
    logic       got_done, obs_result, post_done, post_busy, post_result;
    logic [4:0] obs_opcnt;

    rails_seq_ctrl #(.MAX_CARS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data      (data),
        .busy      (busy),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_car   (cmd_car),
        .done      (done),
        .result    (result),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_opcnt();
`ifdef RAILS_OPCNT_EN
        return 5'(exp_q.size());
`else
        return 5'd0;
`endif
    endfunction

    // Station model: cars 1..N arrive in order, a stack holds them, departures follow ord.
    task automatic build_expected();
        logic [3:0] stk [$];
        int nxt = 1;
        int p   = 0;
        int t;
        exp_q.delete();
        exp_result = 1'b0;
        while (1) begin
            t = int'(ord[p]);
            if (stk.size() > 0 && int'(stk[stk.size()-1]) == t) begin
                void'(stk.pop_back());
                exp_q.push_back({1'b1, 4'(t)});
                p++;
                if (p == ord_n) begin
                    exp_result = 1'b1;
                    break;
                end
            end else if (nxt <= t && t <= ord_n) begin
                stk.push_back(4'(nxt));
                exp_q.push_back({1'b0, 4'(nxt)});
                nxt++;
            end else begin
                break;
            end
        end
    endtask

    // Loads one job with random LOAD gaps, then records commands while injecting input noise.
    task automatic run_job(input int stop_after);
        obs_q.delete();
        got_done    = 1'b0;
        obs_result  = 1'b0;
        obs_opcnt   = 5'd0;
        post_done   = 1'b1;
        post_busy   = 1'b1;
        post_result = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        data     = 4'(ord_n);
        for (int i = 0; i < ord_n; i++) begin
            @(negedge clk);
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                data     = 4'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            data     = ord[i];
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) obs_q.push_back({cmd_op, cmd_car});
            if (done === 1'b1) begin
                got_done   = 1'b1;
                obs_result = result;
                obs_opcnt  = op_count;
                break;
            end
            if (stop_after > 0 && obs_q.size() >= stop_after) break;
            in_valid = 1'($urandom);
            data     = 4'($urandom);
        end
        in_valid = 1'b0;
        if (got_done) begin
            @(negedge clk);
            post_done   = done;
            post_busy   = busy;
            post_result = result;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        data     = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_busy_done: got %b, required 00", {busy, done});
        end
        n_checks++;
        if ({cmd_valid, cmd_op, cmd_car} !== 6'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_cmd: got %h, required 00", {cmd_valid, cmd_op, cmd_car});
        end
        n_checks++;
        if ({result, op_count} !== 6'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_result_cnt: got %h, required 00", {result, op_count});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_in_order();
        ord_n = 5;
        for (int i = 0; i < 5; i++) ord[i] = 4'(i + 1);
        exp_q = '{5'h01, 5'h11, 5'h02, 5'h12, 5'h03, 5'h13, 5'h04, 5'h14, 5'h05, 5'h15};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL in_order_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL in_order_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL in_order_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b1) begin n_fail++; $display("[TB] FAIL in_order_result: got %b, required 1", obs_result); end
        n_checks++;
        if (obs_opcnt !== exp_opcnt()) begin n_fail++; $display("[TB] FAIL in_order_opcnt: got %0d, required %0d", obs_opcnt, exp_opcnt()); end
        n_checks++;
        if ({post_done, post_busy, post_result} !== 3'b001) begin n_fail++; $display("[TB] FAIL in_order_after: got %b, required 001", {post_done, post_busy, post_result}); end
    endtask

    task automatic test_reverse();
        ord_n = 3; ord[0] = 4'd3; ord[1] = 4'd2; ord[2] = 4'd1;
        exp_q = '{5'h01, 5'h02, 5'h03, 5'h13, 5'h12, 5'h11};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL reverse_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL reverse_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL reverse_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b1) begin n_fail++; $display("[TB] FAIL reverse_result: got %b, required 1", obs_result); end
        n_checks++;
        if (obs_opcnt !== exp_opcnt()) begin n_fail++; $display("[TB] FAIL reverse_opcnt: got %0d, required %0d", obs_opcnt, exp_opcnt()); end
    endtask

    task automatic test_reset_mid_run();
        logic bad = 1'b0;
        ord_n = 5; ord[0] = 4'd5; ord[1] = 4'd4; ord[2] = 4'd3; ord[3] = 4'd2; ord[4] = 4'd1;
        run_job(3);
        n_checks++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL midrun_cmds_before_reset: got %0d, required 3", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0], obs_q[1], obs_q[2]} !== {5'h01, 5'h02, 5'h03}) begin
                n_fail++;
                $display("[TB] FAIL midrun_first_cmds: got %h, required 010203", {obs_q[0], obs_q[1], obs_q[2]});
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, cmd_valid, cmd_op, cmd_car, done, result, op_count} !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset_outputs: got %h, required 0", {busy, cmd_valid, cmd_op, cmd_car, done, result, op_count});
        end
        repeat (3) begin @(negedge clk); if (done !== 1'b0) bad = 1'b1; end
        reset = 1'b0;
        repeat (3) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) bad = 1'b1; end
        n_checks++;
        if (bad) begin n_fail++; $display("[TB] FAIL midrun_no_done: activity seen=%b, required 0", bad); end
        ord_n = 2; ord[0] = 4'd2; ord[1] = 4'd1;
        exp_q = '{5'h01, 5'h02, 5'h12, 5'h11};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL midrun_next_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL midrun_next_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL midrun_next_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b1) begin n_fail++; $display("[TB] FAIL midrun_next_result: got %b, required 1", obs_result); end
    endtask

    task automatic test_partial_fail();
        ord_n = 5; ord[0] = 4'd5; ord[1] = 4'd4; ord[2] = 4'd1; ord[3] = 4'd2; ord[4] = 4'd3;
        exp_q = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h15, 5'h14};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL partial_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL partial_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL partial_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b0) begin n_fail++; $display("[TB] FAIL partial_result: got %b, required 0", obs_result); end
        n_checks++;
        if (obs_opcnt !== exp_opcnt()) begin n_fail++; $display("[TB] FAIL partial_opcnt: got %0d, required %0d", obs_opcnt, exp_opcnt()); end
        n_checks++;
        if ({post_done, post_busy, post_result} !== 3'b000) begin n_fail++; $display("[TB] FAIL partial_after: got %b, required 000", {post_done, post_busy, post_result}); end
    endtask

    task automatic test_bad_length();
        logic bad = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; data = 4'd0;
        @(negedge clk);
        if (busy !== 1'b0) bad = 1'b1;
        data = 4'd11;
        @(negedge clk);
        if (busy !== 1'b0) bad = 1'b1;
        data = 4'd15;
        @(negedge clk);
        if (busy !== 1'b0) bad = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if (bad) begin n_fail++; $display("[TB] FAIL badlen_busy: busy seen=%b, required 0", bad); end
        ord_n = 1; ord[0] = 4'd1;
        exp_q = '{5'h01, 5'h11};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL badlen_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL badlen_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL badlen_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b1) begin n_fail++; $display("[TB] FAIL badlen_result: got %b, required 1", obs_result); end
    endtask

    task automatic test_duplicate();
        ord_n = 4; ord[0] = 4'd2; ord[1] = 4'd2; ord[2] = 4'd1; ord[3] = 4'd3;
        exp_q = '{5'h01, 5'h02, 5'h12};
        run_job(0);
        n_checks++;
        if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL dup_done: got %b, required 1", got_done); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL dup_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL dup_cmd%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++;
        if (obs_result !== 1'b0) begin n_fail++; $display("[TB] FAIL dup_result: got %b, required 0", obs_result); end
    endtask

    // Random permutations of 1..N, sometimes with one entry replaced by an arbitrary number.
    task automatic test_random();
        int         j;
        logic [3:0] tmp;
        for (int job = 0; job < 30; job++) begin
            ord_n = $urandom_range(1, 10);
            for (int i = 0; i < ord_n; i++) ord[i] = 4'(i + 1);
            for (int i = ord_n - 1; i > 0; i--) begin
                j      = $urandom_range(0, i);
                tmp    = ord[i];
                ord[i] = ord[j];
                ord[j] = tmp;
            end
            if ($urandom_range(0, 3) == 0) ord[$urandom_range(0, ord_n - 1)] = 4'($urandom_range(0, 15));
            build_expected();
            run_job(0);
            n_checks++;
            if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL rand%0d_done: got %b, required 1", job, got_done); end
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand%0d_count: got %0d, required %0d", job, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand%0d_cmd%0d: got %h, required %h", job, i, obs_q[i], exp_q[i]); end
            end
            n_checks++;
            if (obs_result !== exp_result) begin n_fail++; $display("[TB] FAIL rand%0d_result: got %b, required %b", job, obs_result, exp_result); end
            n_checks++;
            if (obs_opcnt !== exp_opcnt()) begin n_fail++; $display("[TB] FAIL rand%0d_opcnt: got %0d, required %0d", job, obs_opcnt, exp_opcnt()); end
            n_checks++;
            if ({post_done, post_busy, post_result} !== {2'b00, exp_result}) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_after: got %b, required %b", job, {post_done, post_busy, post_result}, {2'b00, exp_result});
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_reverse();
        test_reset_mid_run();
        test_partial_fail();
        test_bad_length();
        test_duplicate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
